fp_add_controller: RTL and testbench
====================================

// Module: fp_add_controller
// PURPOSE
//  Multi-cycle sequencer for the single-precision add/sub datapath. Unpacks two IEEE-754 operands and
//  aligns the smaller operand (exp diff, sticky). Drives the 28-bit mantissa adder with carry renormalise.
//  Then left-normalises one bit per cycle and packs the result. One operation in flight; valid/ready on both sides.
// PARAMETERS
//  EXP_W   8   exponent width
//  MANT_W  28  internal mantissa width: {hidden, frac[22:0], 4 guard bits}
//  FRAC_W  23  stored fraction width
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  in_valid   in   1   operands valid
//  in_ready   out  1   controller can accept (IDLE only)
//  op_a       in   32  operand A, IEEE-754 single
//  op_b       in   32  operand B, IEEE-754 single
//  sub        in   1   1: compute A-B (B sign inverted at accept)
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   consumer accepts result
//  result     out  32  packed result
//  flags      out  3   {invalid, overflow, underflow}, valid with out_valid
//  busy       out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; in_ready=1, out_valid=0, result=0, flags=0, busy=0, all datapath regs 0.
//  States: IDLE -> ALIGN -> ADD -> NORM -> OUT -> IDLE; special operands take IDLE -> OUT directly.
//  IDLE: in_ready=1; on in_valid&in_ready latch operands, signB^=sub.
//   Exp==0 operand treated as zero (denormals flushed).
//   Exp==255 -> special: any NaN, or inf-inf of opposite sign -> 0x7FC00000, invalid=1; else inf of that sign.
//  ALIGN (1 cycle): larger-magnitude operand = X (compare {exp,frac}); exp_r=exp_X.
//   Y mantissa >> (exp_X-exp_Y); shifted-out bits OR into bit0 (sticky).
//   diff>=MANT_W -> Y mantissa = 0 with bit0=sticky of any nonzero Y.
//  ADD (1 cycle): same sign -> {carry,m}=mX+mY; carry -> m={1,m[27:1]}, exp_r+=1.
//   Opposite sign -> m=mX-mY (never negative, X larger); result sign = sign of X.
//   exp_r reaching 255 -> overflow: result=signed inf, overflow=1, goto OUT.
//  NORM: per cycle, if m==0 -> result +0, exit.
//   If m[27]==1 -> exit; else m<<=1, exp_r-=1.
//   exp_r would drop to 0 -> flush to signed zero, underflow=1, exit. Exit always costs one NORM cycle.
//  OUT: result={sign,exp_r,m[26:4]} (round toward zero, guard bits dropped); out_valid=1.
//   result/flags stable while out_valid&!out_ready. On out_ready: out_valid=0, state=IDLE.
//   in_ready asserts next cycle (no same-cycle accept).
//  Latency: accept edge -> out_valid = 4+k cycles, k = left shifts in NORM (0..26).
//   Special operand: 1 cycle.
//  Exact cancellation (A-A) -> +0x00000000, no flags.
//  in_valid while busy ignored; operands need not be held after acceptance.
//  rst mid-operation: immediate return to reset values, in-flight op discarded, no out_valid.
// TESTING
//  0x3F800000 + 0x3F800000 (sub=0) -> 0x40000000, flags=0, out_valid 4 cycles after accept.
//  0x3FC00000 - 0x3FA00000 (sub=1) -> 0x3E800000, k=2, out_valid 6 cycles after accept.
//  0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
//  0x7FC00000 + 0x3F800000 -> 0x7FC00000, invalid=1, 1-cycle latency.
//  0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1.
//  0x3F800000 - 0x3F800000 -> 0x00000000 exact zero.
//  0x00800000 - 0x00800001 (sub=1) -> underflow=1, signed zero.
//  1.0+1.0 with out_ready low 5 cycles -> result/out_valid held constant, in_ready=0 throughout.
//  1.0+1.0 after one full op -> in_ready=1 cycle after out_ready handshake.
//  rst pulsed during NORM of 0x3FC00000-0x3FA00000 -> all outputs at reset values.
//   Next op 1.0+1.0 -> correct 0x40000000.

Source files
------------

// File: rtl/fp_add_controller_if.sv
// Handshake and data bundle for the single-precision add/sub sequencer.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   Input side: the producer drives in_valid/op_a/op_b/sub. in_ready is high only
//   while the controller is idle. Operands are captured on the transfer edge and
//   need not be held afterwards. in_valid while in_ready is low is ignored.
//   Output side: out_valid rises with result/flags already stable. All three hold
//   until the edge where out_ready is sampled high. out_valid then drops and the
//   controller goes back to idle.
//
// state_dbg mirrors the FSM state encoding:
//   0 IDLE, 1 ALIGN, 2 ADD, 3 NORM, 4 OUT.
interface fp_add_controller_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic        busy;
  logic [2:0]  state_dbg;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, flags, busy, state_dbg
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, flags, busy, state_dbg
  );
endinterface

// File: rtl/fp_add_controller.sv
// Multi-cycle IEEE-754 single-precision add/sub sequencer.
// IDLE -> ALIGN -> ADD -> NORM (1+k cycles) -> OUT -> IDLE.
// NaN/inf operands go straight from IDLE to OUT.
// Denormals are flushed to zero. Rounding is toward zero: the guard bits are dropped at pack time.
module fp_add_controller #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 28,
  parameter int FRAC_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  fp_add_controller_if.slave  bus
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int GUARD = MANT_W - 1 - FRAC_W;

  localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
  localparam logic [EXP_W-1:0]  EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0]  DIFF_LIM = EXP_W'(MANT_W);
  localparam logic [MANT_W-1:0] QNAN_M   = {2'b01, {(MANT_W-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched operands (B sign already adjusted for subtraction)
  logic              a_sign_q, b_sign_q;
  logic [EXP_W-1:0]  a_exp_q, b_exp_q;
  logic [FRAC_W-1:0] a_frac_q, b_frac_q;

  // Working datapath
  logic              sign_q, sign_y_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] m_q, mx_q, my_q;
  logic [2:0]        flags_q;

  // Output registers
  logic [W-1:0]      result_q;
  logic [2:0]        res_flags_q;
  logic              out_valid_q;

  // ---------------------------------------------------------------------------
  // Operand decode at the input port (used only on the accept edge)
  // ---------------------------------------------------------------------------
  logic              a_sign_in, b_sign_in;
  logic [EXP_W-1:0]  a_exp_in, b_exp_in;
  logic [FRAC_W-1:0] a_frac_in, b_frac_in;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic              special_in, spec_invalid, spec_sign;

  assign a_sign_in = bus.op_a[W-1];
  assign a_exp_in  = bus.op_a[W-2 -: EXP_W];
  assign a_frac_in = bus.op_a[FRAC_W-1:0];
  assign b_sign_in = bus.op_b[W-1] ^ bus.sub;
  assign b_exp_in  = bus.op_b[W-2 -: EXP_W];
  assign b_frac_in = bus.op_b[FRAC_W-1:0];

  assign a_nan = (a_exp_in == EXP_MAX) && (a_frac_in != '0);
  assign b_nan = (b_exp_in == EXP_MAX) && (b_frac_in != '0);
  assign a_inf = (a_exp_in == EXP_MAX) && (a_frac_in == '0);
  assign b_inf = (b_exp_in == EXP_MAX) && (b_frac_in == '0);

  assign special_in   = (a_exp_in == EXP_MAX) || (b_exp_in == EXP_MAX);
  assign spec_invalid = a_nan || b_nan || (a_inf && b_inf && (a_sign_in != b_sign_in));
  assign spec_sign    = a_inf ? a_sign_in : b_sign_in;

  // ---------------------------------------------------------------------------
  // ALIGN: pick the larger magnitude as X and shift Y right, with a sticky bit
  // ---------------------------------------------------------------------------
  logic [FRAC_W-1:0] a_frac_f, b_frac_f;
  logic [MANT_W-1:0] ma, mb;
  logic              a_is_x;
  logic              x_sign, y_sign;
  logic [EXP_W-1:0]  x_exp, y_exp, exp_diff;
  logic [MANT_W-1:0] mx_raw, my_raw, lost_mask, my_al;

  assign a_frac_f = (a_exp_q == '0) ? '0 : a_frac_q;
  assign b_frac_f = (b_exp_q == '0) ? '0 : b_frac_q;
  assign ma       = (a_exp_q == '0) ? '0 : {1'b1, a_frac_q, {GUARD{1'b0}}};
  assign mb       = (b_exp_q == '0) ? '0 : {1'b1, b_frac_q, {GUARD{1'b0}}};
  assign a_is_x   = {a_exp_q, a_frac_f} >= {b_exp_q, b_frac_f};

  // Operand swap and alignment shift with sticky collection
  always_comb begin
    x_sign    = a_is_x ? a_sign_q : b_sign_q;
    y_sign    = a_is_x ? b_sign_q : a_sign_q;
    x_exp     = a_is_x ? a_exp_q  : b_exp_q;
    y_exp     = a_is_x ? b_exp_q  : a_exp_q;
    mx_raw    = a_is_x ? ma : mb;
    my_raw    = a_is_x ? mb : ma;
    exp_diff  = x_exp - y_exp;
    lost_mask = '0;
    my_al     = '0;
    if (exp_diff >= DIFF_LIM) begin
      my_al = {{(MANT_W-1){1'b0}}, |my_raw};
    end else begin
      lost_mask = ~({MANT_W{1'b1}} << exp_diff);
      my_al     = (my_raw >> exp_diff) | {{(MANT_W-1){1'b0}}, |(my_raw & lost_mask)};
    end
  end

  // ---------------------------------------------------------------------------
  // ADD / NORM helpers
  // ---------------------------------------------------------------------------
  logic [MANT_W:0]   sum;
  logic [MANT_W-1:0] diff_m;
  logic [EXP_W-1:0]  exp_inc;
  logic              same_sign, add_ovf, norm_exit;

  assign sum       = {1'b0, mx_q} + {1'b0, my_q};
  assign diff_m    = mx_q - my_q;
  assign exp_inc   = exp_q + EXP_ONE;
  assign same_sign = (sign_q == sign_y_q);
  assign add_ovf   = same_sign && sum[MANT_W] && (exp_inc == EXP_MAX);
  // Exit when zero, already normalised, or one more shift would reach exponent 0
  assign norm_exit = (m_q == '0) || m_q[MANT_W-1] || (exp_q <= EXP_ONE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = special_in ? S_OUT : S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = add_ovf ? S_OUT : S_NORM;
      S_NORM:  if (norm_exit) state_d = S_OUT;
      S_OUT:   if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers, advanced according to the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      a_exp_q     <= '0;
      b_exp_q     <= '0;
      a_frac_q    <= '0;
      b_frac_q    <= '0;
      sign_q      <= 1'b0;
      sign_y_q    <= 1'b0;
      exp_q       <= '0;
      m_q         <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      flags_q     <= '0;
      result_q    <= '0;
      res_flags_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sign_q <= a_sign_in;
            b_sign_q <= b_sign_in;
            a_exp_q  <= a_exp_in;
            b_exp_q  <= b_exp_in;
            a_frac_q <= a_frac_in;
            b_frac_q <= b_frac_in;
            flags_q  <= '0;
            if (special_in) begin
              // Canonical quiet NaN is positive with only the top fraction bit set
              sign_q  <= spec_invalid ? 1'b0 : spec_sign;
              exp_q   <= EXP_MAX;
              m_q     <= spec_invalid ? QNAN_M : '0;
              flags_q <= {spec_invalid, 2'b00};
            end
          end
        end
        S_ALIGN: begin
          sign_q   <= x_sign;
          sign_y_q <= y_sign;
          exp_q    <= x_exp;
          mx_q     <= mx_raw;
          my_q     <= my_al;
        end
        S_ADD: begin
          if (same_sign) begin
            if (sum[MANT_W]) begin
              exp_q <= exp_inc;
              if (exp_inc == EXP_MAX) begin
                m_q        <= '0;
                flags_q[1] <= 1'b1;
              end else begin
                m_q <= {1'b1, sum[MANT_W-1:1]};
              end
            end else begin
              m_q <= sum[MANT_W-1:0];
            end
          end else begin
            m_q <= diff_m;
          end
        end
        S_NORM: begin
          if (m_q == '0) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
          end else if (m_q[MANT_W-1]) begin
            exp_q <= exp_q;
          end else if (exp_q <= EXP_ONE) begin
            exp_q      <= '0;
            m_q        <= '0;
            flags_q[0] <= 1'b1;
          end else begin
            m_q   <= m_q << 1;
            exp_q <= exp_q - EXP_ONE;
          end
        end
        S_OUT: begin
          // First OUT cycle packs the result, later cycles hold it until taken
          if (!out_valid_q) begin
            result_q    <= {sign_q, exp_q, m_q[MANT_W-2 -: FRAC_W]};
            res_flags_q <= flags_q;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = res_flags_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fp_add_controller.sv
// Directed bench for fp_add_controller: every operation pushes its expected
// {flags, result} on a queue when driven, and the entry is popped and compared when out_valid appears.
module tb_fp_add_controller;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_controller_if bus ();

  fp_add_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, wait for the result, optionally stall, then hand it off.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] res, input logic [2:0] fl,
                       input int lat, input int stall, input bit noise);
    logic [34:0] e;
    int n;
    exp_q.push_back({fl, res});
    check("in_ready_idle", bus.in_ready, 1'b1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = noise;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.sub      = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 64);
    bus.in_valid = 1'b0;
    check("out_valid_seen", bus.out_valid, 1'b1);
    if (!bus.out_valid) begin
      void'(exp_q.pop_front());
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      return;
    end
    check("latency", n, lat);
    e = exp_q.pop_front();
    check("result", bus.result, e[31:0]);
    check("flags", bus.flags, e[34:32]);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_hold", {bus.out_valid, bus.in_ready, bus.busy, bus.flags, bus.result},
            {1'b1, 1'b0, 1'b1, e});
    end
    check("pre_handshake", {bus.out_valid, bus.in_ready}, 2'b10);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_handshake", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {bus.in_ready, bus.out_valid, bus.busy, bus.flags, bus.result},
          {1'b1, 1'b0, 1'b0, 3'b000, 32'h0});
    check("reset_state", bus.state_dbg, 3'd0);
    rst = 1'b0;
    tick();

    //     a             b             sub   result        flags   lat stall noise
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4, 0, 1'b0);
    do_op(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 3'b000, 6, 0, 1'b1);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010, 3, 0, 1'b0);
    do_op(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1, 0, 1'b0);
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 1, 0, 1'b0);
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4, 0, 1'b0);
    do_op(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001, 4, 0, 1'b0);
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4, 5, 1'b0);
    do_op(32'h40000000, 32'h3F000000, 1'b0, 32'h40200000, 3'b000, 4, 0, 1'b0);
    do_op(32'h3F800000, 32'h30800000, 1'b1, 32'h3F7FFFFF, 3'b000, 5, 0, 1'b0);
    do_op(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b000, 4, 0, 1'b0);
    do_op(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 4, 0, 1'b0);
    do_op(32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 3'b000, 4, 0, 1'b0);
    do_op(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 1, 0, 1'b0);
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 1, 0, 1'b0);

    // Reset in the middle of NORM: the in-flight op must vanish
    bus.op_a     = 32'h3FC00000;
    bus.op_b     = 32'h3FA00000;
    bus.sub      = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("mid_norm_state", bus.state_dbg, 3'd3);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {bus.in_ready, bus.out_valid, bus.busy, bus.flags, bus.result},
          {1'b1, 1'b0, 1'b0, 3'b000, 32'h0});
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_out_after_rst", {bus.out_valid, bus.busy}, 2'b00);
    end
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4, 0, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
